yarvi_wb_arb: RTL and testbench

Write-port arbiter and load scoreboard for the YARVI register file. It merges the execute-stage result stream (ex, no backpressure) and the load-return stream (ld, valid/ready handshake) onto the single registered RF write port `wb_valid/wb_rd/wb_val`. A starvation counter bounds load latency by requesting an execute bubble. An optional scoreboard tracks registers with outstanding loads so decode can stall.

---
 rtl/yarvi_wb_arb.sv | 162 ++++++++++++++++
 tb/tb_yarvi_wb_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/yarvi_wb_arb.sv
// yarvi_wb_arb: register-file write-port arbiter with load starvation guard
// and optional load scoreboard.
//
// The execute stream (ex_*) has absolute priority and cannot be stalled. The
// load-return stream (ld_*) is handshaken with ld_ready = !ex_valid. After
// STARVE_LIMIT consecutive refused load cycles, ex_hold asks upstream for an
// execute bubble so the load can drain. The winner is registered onto wb_*.
//
// Optional feature macro: YARVI_WB_SCOREBOARD_EN
//   defined   : sb_busy tracks registers with outstanding loads; issuing to a
//               busy register or executing to a busy register sets err.
//   undefined : sb_busy is tied to 0, iss_* are ignored.
//
// Ports:
//   clock, reset_n           rising-edge clock, async active-low reset
//   ex_valid/ex_rd/ex_val    execute result (no backpressure)
//   ld_valid/ld_ready/ld_rd/ld_val  load return (valid/ready)
//   iss_valid/iss_rd         load issue notification (scoreboard set)
//   wb_valid/wb_rd/wb_val    registered RF write port
//   ex_hold                  request an execute bubble (registered-state decode)
//   sb_busy                  per-register outstanding-load bits
//   err                      sticky protocol-violation flag
module yarvi_wb_arb #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned XMSB         = 31
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            ex_valid,
   input  logic [4:0]      ex_rd,
   input  logic [XMSB:0]   ex_val,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [XMSB:0]   ld_val,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XMSB:0]   wb_val,
   output logic            ex_hold,
   output logic [31:0]     sb_busy,
   output logic            err
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned NREG  = 32;

   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_nxt;
   logic             ld_take;
   logic             err_set;

   // ex always wins the port; a load is taken only in ex-free cycles.
   assign ld_ready = !ex_valid;
   assign ld_take  = ld_valid && !ex_valid;

   // Decoded from the counter register only, so no input reaches ex_hold.
   assign ex_hold  = (starve_cnt == CNT_W'(STARVE_LIMIT));

   // Starvation counter: counts refused load cycles, saturates at the limit.
   always_comb begin
      starve_nxt = '0;
      if (ld_valid && !ld_ready) begin
         if (starve_cnt == CNT_W'(STARVE_LIMIT))
            starve_nxt = starve_cnt;
         else
            starve_nxt = starve_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         starve_cnt <= '0;
      else
         starve_cnt <= starve_nxt;
   end

   // Registered write port; rd=0 writes are consumed but never enabled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_val   <= '0;
      end else if (ex_valid) begin
         wb_valid <= (ex_rd != 5'd0);
         wb_rd    <= ex_rd;
         wb_val   <= ex_val;
      end else if (ld_take) begin
         wb_valid <= (ld_rd != 5'd0);
         wb_rd    <= ld_rd;
         wb_val   <= ld_val;
      end else begin
         wb_valid <= 1'b0;
      end
   end

`ifdef YARVI_WB_SCOREBOARD_EN
   logic            wb_from_ld;
   logic [NREG-1:0] sb_q;
   logic [NREG-1:0] sb_set;
   logic [NREG-1:0] sb_clr;
   logic [NREG-1:0] busy_eff;
   logic [NREG-1:0] sb_nxt;

   // Remembers whether the write currently on wb_* came from the load stream.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         wb_from_ld <= 1'b0;
      else
         wb_from_ld <= ld_take && !ex_valid;
   end

   // Set on issue, clear when a load write is on wb_*; set wins on overlap.
   // A register being cleared this edge is not treated as busy for the
   // WAW checks, since its load has already reached the write port.
   always_comb begin
      sb_set   = '0;
      sb_clr   = '0;
      if (iss_valid && (iss_rd != 5'd0))
         sb_set[iss_rd] = 1'b1;
      if (wb_valid && wb_from_ld)
         sb_clr[wb_rd] = 1'b1;
      busy_eff = sb_q & ~sb_clr;
      sb_nxt   = busy_eff | sb_set;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         sb_q <= '0;
      else
         sb_q <= sb_nxt;
   end

   assign sb_busy = sb_q;

   always_comb begin
      err_set = ex_valid && ex_hold;
      if (iss_valid && (iss_rd != 5'd0) && busy_eff[iss_rd])
         err_set = 1'b1;
      if (ex_valid && busy_eff[ex_rd])
         err_set = 1'b1;
   end
`else
   logic unused_iss;
   assign unused_iss = &{1'b0, iss_valid, iss_rd};
   assign sb_busy    = '0;

   always_comb begin
      err_set = ex_valid && ex_hold;
   end
`endif

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         err <= 1'b0;
      else if (err_set)
         err <= 1'b1;
   end

endmodule

// File: tb/tb_yarvi_wb_arb.sv
// Directed self-checking bench for yarvi_wb_arb (STARVE_LIMIT=4, 32-bit data).
module tb_yarvi_wb_arb;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic [31:0] ex_val;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_val;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_val;
   logic        ex_hold;
   logic [31:0] sb_busy;
   logic        err;

   int n_chk  = 0;
   int n_pass = 0;

   yarvi_wb_arb #(.STARVE_LIMIT(4), .XMSB(31)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .ex_valid (ex_valid),
      .ex_rd    (ex_rd),
      .ex_val   (ex_val),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_rd    (ld_rd),
      .ld_val   (ld_val),
      .iss_valid(iss_valid),
      .iss_rd   (iss_rd),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_val   (wb_val),
      .ex_hold  (ex_hold),
      .sb_busy  (sb_busy),
      .err      (err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      ex_valid  = 1'b0; ex_rd = '0; ex_val = '0;
      ld_valid  = 1'b0; ld_rd = '0; ld_val = '0;
      iss_valid = 1'b0; iss_rd = '0;
      #3;
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_wb_rd",    64'(wb_rd),    64'd0);
      check("rst_wb_val",   64'(wb_val),   64'd0);
      check("rst_ex_hold",  64'(ex_hold),  64'd0);
      check("rst_sb_busy",  64'(sb_busy),  64'd0);
      check("rst_err",      64'(err),      64'd0);
      check("rst_ld_ready", 64'(ld_ready), 64'd1);
      reset_n = 1'b1;
      step();

      // Simple ex write.
      ex_valid = 1'b1; ex_rd = 5'd5; ex_val = 32'h1234;
      #1 check("ex_ld_ready", 64'(ld_ready), 64'd0);
      step();
      check("ex_wb_valid", 64'(wb_valid), 64'd1);
      check("ex_wb_rd",    64'(wb_rd),    64'd5);
      check("ex_wb_val",   64'(wb_val),   64'h1234);

      // Starvation: ex continuous while ld waits; hold after 4 refused cycles.
      ld_valid = 1'b1; ld_rd = 5'd9; ld_val = 32'h5555;
      for (int i = 0; i < 4; i++) begin
         ex_rd = 5'(6 + i); ex_val = 32'hA000 + 32'(i);
         #1;
         check("starve_ld_ready", 64'(ld_ready), 64'd0);
         check("starve_no_hold",  64'(ex_hold),  64'd0);
         step();
      end
      check("starve_hold",   64'(ex_hold), 64'd1);
      check("starve_last_rd",64'(wb_rd),   64'd9);
      check("starve_last_val",64'(wb_val), 64'hA003);
      ex_valid = 1'b0;
      #1 check("bubble_ld_ready", 64'(ld_ready), 64'd1);
      step();
      ld_valid = 1'b0;
      check("ld_wb_valid", 64'(wb_valid), 64'd1);
      check("ld_wb_rd",    64'(wb_rd),    64'd9);
      check("ld_wb_val",   64'(wb_val),   64'h5555);
      check("ld_hold_clr", 64'(ex_hold),  64'd0);
      check("ld_no_err",   64'(err),      64'd0);

      // Load to x0: handshaken but discarded.
      ld_valid = 1'b1; ld_rd = 5'd0; ld_val = 32'hFF;
      #1 check("x0_ld_ready", 64'(ld_ready), 64'd1);
      step();
      ld_valid = 1'b0;
      check("x0_wb_valid", 64'(wb_valid), 64'd0);
      step();
      check("idle_wb_valid", 64'(wb_valid), 64'd0);

      // Protocol violation: ex while ex_hold; ex still wins, err sticky.
      ex_valid = 1'b1; ex_rd = 5'd4; ex_val = 32'h44;
      ld_valid = 1'b1; ld_rd = 5'd10; ld_val = 32'hA0;
      for (int i = 0; i < 4; i++) step();
      check("viol_hold",   64'(ex_hold), 64'd1);
      check("viol_pre_err",64'(err),     64'd0);
      ex_rd = 5'd11; ex_val = 32'hBB;
      step();
      check("viol_err",    64'(err),     64'd1);
      check("viol_wb_rd",  64'(wb_rd),   64'd11);
      check("viol_wb_val", 64'(wb_val),  64'hBB);
      check("viol_sat",    64'(ex_hold), 64'd1);
      ex_valid = 1'b0;
      step();
      ld_valid = 1'b0;
      check("viol_ld_rd",  64'(wb_rd),   64'd10);
      check("viol_ld_val", 64'(wb_val),  64'hA0);
      check("err_sticky",  64'(err),     64'd1);

      // Asynchronous reset with a load pending.
`ifdef YARVI_WB_SCOREBOARD_EN
      iss_valid = 1'b1; iss_rd = 5'd7;
      step();
      iss_valid = 1'b0;
`endif
      ex_valid = 1'b1; ex_rd = 5'd3; ex_val = 32'h77;
      ld_valid = 1'b1; ld_rd = 5'd7; ld_val = 32'h700;
      step();
      check("pre_rst_wb_valid", 64'(wb_valid), 64'd1);
`ifdef YARVI_WB_SCOREBOARD_EN
      check("pre_rst_busy", 64'(sb_busy), 64'h80);
`endif
      ex_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      check("arst_wb_valid", 64'(wb_valid), 64'd0);
      check("arst_wb_rd",    64'(wb_rd),    64'd0);
      check("arst_wb_val",   64'(wb_val),   64'd0);
      check("arst_ex_hold",  64'(ex_hold),  64'd0);
      check("arst_sb_busy",  64'(sb_busy),  64'd0);
      check("arst_err",      64'(err),      64'd0);
      #1 reset_n = 1'b1;
      #1 check("reoffer_ld_ready", 64'(ld_ready), 64'd1);
      step();
      ld_valid = 1'b0;
      check("reoffer_wb_valid", 64'(wb_valid), 64'd1);
      check("reoffer_wb_rd",    64'(wb_rd),    64'd7);
      check("reoffer_wb_val",   64'(wb_val),   64'h700);
      step();

`ifdef YARVI_WB_SCOREBOARD_EN
      // Scoreboard set, clear, set-wins and WAW error.
      iss_valid = 1'b1; iss_rd = 5'd7;
      step();
      iss_valid = 1'b0;
      check("sb_set", 64'(sb_busy), 64'h80);
      ld_valid = 1'b1; ld_rd = 5'd7; ld_val = 32'h7777;
      step();
      ld_valid = 1'b0;
      check("sb_ld_wb_rd", 64'(wb_rd),   64'd7);
      check("sb_held",     64'(sb_busy), 64'h80);
      iss_valid = 1'b1; iss_rd = 5'd7;
      step();
      iss_valid = 1'b0;
      check("sb_set_wins", 64'(sb_busy), 64'h80);
      check("sb_no_err",   64'(err),     64'd0);
      ld_valid = 1'b1; ld_rd = 5'd7; ld_val = 32'h7778;
      step();
      ld_valid = 1'b0;
      check("sb_still_busy", 64'(sb_busy), 64'h80);
      step();
      check("sb_cleared", 64'(sb_busy), 64'h0);
      iss_valid = 1'b1; iss_rd = 5'd7;
      step();
      iss_valid = 1'b0;
      ex_valid = 1'b1; ex_rd = 5'd7; ex_val = 32'h1;
      step();
      ex_valid = 1'b0;
      check("waw_err",    64'(err),    64'd1);
      check("waw_wb_rd",  64'(wb_rd),  64'd7);
      check("waw_wb_val", 64'(wb_val), 64'h1);
      step();
      check("waw_err_sticky", 64'(err), 64'd1);
`else
      // Without the scoreboard, issues are ignored entirely.
      iss_valid = 1'b1; iss_rd = 5'd7;
      step();
      check("nosb_busy", 64'(sb_busy), 64'h0);
      step();
      iss_valid = 1'b0;
      check("nosb_err", 64'(err), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
